lane_deskew_fifo_rx: RTL

LANE_DESKEW_FIFO_RX -- requirements
Module: lane_deskew_fifo_rx

---
 rtl/pcs_pkg.sv | 13 +
 rtl/deskew_lane_fifo.sv | 56 +++++
 rtl/lane_deskew_fifo_rx.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/pcs_pkg.sv
// Shared definitions for the PCS receive deskew path: FSM states and default geometry.
package pcs_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_AM = 2'd1,
    ALIGNED = 2'd2
  } state_t;

  localparam int unsigned BLOCK_W_DEF = 66;
  localparam int unsigned DEPTH_DEF   = 32;

endpackage

// File: rtl/deskew_lane_fifo.sv
// Single-lane deskew buffer: circular storage with occupancy counter and synchronous flush.
module deskew_lane_fifo #(
  parameter int unsigned WIDTH = 67,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

  // A full buffer still accepts a write when the same cycle pops an entry.
  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_en & (~full | do_rd);

  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(do_wr) - CNT_W'(do_rd);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/lane_deskew_fifo_rx.sv
// Multi-lane receive deskew: buffers each lane from its first alignment marker
// and releases whole rows once every lane holds data.
module lane_deskew_fifo_rx
  import pcs_pkg::*;
#(
  parameter int unsigned LANE_N  = 4,
  parameter int unsigned BLOCK_W = BLOCK_W_DEF,
  parameter int unsigned DEPTH   = DEPTH_DEF,
  parameter int unsigned CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic                      clk,
  input  logic                      nreset,
  input  logic [LANE_N-1:0]         valid_i,
  input  logic [LANE_N-1:0]         lock_i,
  input  logic [LANE_N-1:0]         am_v_i,
  input  logic [LANE_N*BLOCK_W-1:0] block_i,
  output logic                      valid_o,
  output logic                      am_v_o,
  output logic [LANE_N*BLOCK_W-1:0] block_o,
  output logic                      align_o,
  output logic                      skew_err_o,
  output logic [CNT_W-1:0]          skew_o
);

  state_t state;
  state_t state_nxt;

  logic [LANE_N-1:0]         started;
  logic [LANE_N-1:0]         wr_en;
  logic                      rd_en;
  logic [LANE_N-1:0]         empty;
  logic [LANE_N-1:0]         full;
  logic [BLOCK_W:0]          rd_data [LANE_N];
  logic [CNT_W-1:0]          count   [LANE_N];
  logic [LANE_N-1:0]         am_row;
  logic [LANE_N*BLOCK_W-1:0] row_data;
  logic                      lock_all;
  logic                      all_started;
  logic                      overflow;
  logic                      am_mismatch;
  logic                      flush;
  logic                      err_now;
  logic                      fire;
  logic                      capture;
  logic [CNT_W-1:0]          occ;
  logic [CNT_W-1:0]          occ_max;
  logic [CNT_W-1:0]          occ_min;
  logic [CNT_W-1:0]          skew_val;

  for (genvar l = 0; l < LANE_N; l++) begin : g_lane
    deskew_lane_fifo #(
      .WIDTH (BLOCK_W + 1),
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
    ) u_fifo (
      .clk     (clk),
      .nreset  (nreset),
      .flush   (flush),
      .wr_en   (wr_en[l]),
      .wr_data ({am_v_i[l], block_i[l*BLOCK_W +: BLOCK_W]}),
      .rd_en   (rd_en),
      .rd_data (rd_data[l]),
      .count   (count[l]),
      .empty   (empty[l]),
      .full    (full[l])
    );
  end

  // Lane write/read qualification; a lane joins at its first AM while waiting.
  always_comb begin
    wr_en = '0;
    rd_en = 1'b0;
    case (state)
      WAIT_AM: wr_en = valid_i & (started | am_v_i);
      ALIGNED: begin
        wr_en = valid_i;
        rd_en = ~|empty;
      end
      default: ;
    endcase
  end

  always_comb begin
    am_row   = '0;
    row_data = '0;
    for (int unsigned l = 0; l < LANE_N; l++) begin
      am_row[l]                        = rd_data[l][BLOCK_W];
      row_data[l*BLOCK_W +: BLOCK_W]   = rd_data[l][BLOCK_W-1:0];
    end
  end

  assign lock_all    = &lock_i;
  assign all_started = &(started | wr_en);
  assign overflow    = |(wr_en & full) & ~rd_en;
  assign am_mismatch = rd_en & (|am_row) & ~(&am_row);

  always_comb begin
    occ     = '0;
    occ_max = '0;
    occ_min = '1;
    for (int unsigned l = 0; l < LANE_N; l++) begin
      occ = count[l] + CNT_W'(wr_en[l]);
      if (occ > occ_max) occ_max = occ;
      if (occ < occ_min) occ_min = occ;
    end
    skew_val = occ_max - occ_min;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!lock_all) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = WAIT_AM;
        WAIT_AM: if (!overflow && all_started) state_nxt = ALIGNED;
        ALIGNED: if (overflow || am_mismatch) state_nxt = WAIT_AM;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Lock loss outranks buffer errors: it flushes silently and suppresses the row.
  always_comb begin
    err_now = lock_all & (overflow | am_mismatch);
    flush   = ~lock_all | (state == IDLE) | err_now;
    fire    = rd_en & lock_all & ~overflow & ~am_mismatch;
    capture = (state == WAIT_AM) && (state_nxt == ALIGNED);
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset)               started <= '0;
    else if (flush)            started <= '0;
    else if (state == WAIT_AM) started <= started | wr_en;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      valid_o    <= 1'b0;
      am_v_o     <= 1'b0;
      block_o    <= '0;
      align_o    <= 1'b0;
      skew_err_o <= 1'b0;
      skew_o     <= '0;
    end else begin
      valid_o    <= fire;
      am_v_o     <= fire & (&am_row);
      align_o    <= (state_nxt == ALIGNED);
      skew_err_o <= err_now;
      if (fire)    block_o <= row_data;
      if (capture) skew_o  <= skew_val;
    end
  end

endmodule
